// File: rtl/hybrid_func_pipe.sv
// hybrid_func_pipe: 4-stage table + linear-interpolation unit for 1/x, sqrt(x), 1/sqrt(x).
// Optional macro HYBRID_ROUND_EN: round-to-nearest in S4 (default build truncates).
module hybrid_func_pipe #(
    parameter int WL           = 25,
    parameter int LUT_bits     = 27,
    parameter int LUT_addWidth = 11,
    parameter int dWL          = 30,
    parameter int TAG_W        = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             CE,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WL-1:0]    din,
    input  logic [1:0]       FUNCTION,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WL-1:0]    dout,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);
    localparam int XW    = WL - 2 - LUT_addWidth;
    localparam int DEPTH = 1 << LUT_addWidth;
    localparam int PW    = LUT_bits + XW + 1;
    localparam int SH    = LUT_bits + WL - 2 - dWL;
    localparam int C0SH  = dWL - LUT_bits;
    localparam int RB    = dWL - WL;
    localparam int SW    = ((PW > dWL) ? PW : dWL) + 2;

    typedef enum logic [1:0] {
        F_REC  = 2'b00,
        F_SQRT = 2'b01,
        F_ILL  = 2'b10,
        F_ISQT = 2'b11
    } func_e;

    typedef struct packed {
        logic             v;
        func_e            fn;
        logic [WL-3:0]    x;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             v;
        func_e            fn;
        logic [XW-1:0]    xo;
        logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic                v;
        logic                err;
        logic [PW-1:0]       prod;
        logic [LUT_bits-1:0] c0;
        logic [TAG_W-1:0]    tag;
    } s3_t;

    logic [2*LUT_bits-1:0] LUT_rec  [0:DEPTH-1];
    logic [2*LUT_bits-1:0] LUT_sqrt [0:DEPTH-1];
    logic [2*LUT_bits-1:0] LUT_isqt [0:DEPTH-1];

    s1_t s1;
    s2_t s2;
    s3_t s3;

    logic                       stall;
    logic                       adv;
    logic [LUT_addWidth-1:0]    addr;
    logic [2*LUT_bits-1:0]      rd_rec;
    logic [2*LUT_bits-1:0]      rd_sqrt;
    logic [2*LUT_bits-1:0]      rd_isqt;
    logic [2*LUT_bits-1:0]      sel;
    logic signed [LUT_bits-1:0] c1;
    logic [LUT_bits-1:0]        c0;
    logic signed [PW-1:0]       prod;
    logic signed [SW-1:0]       acc;
    logic [SW-1:0]              yq;
    logic [WL-1:0]              ysat;
    logic                       unused_msb;

    assign stall      = out_valid && !out_ready;
    assign in_ready   = CE && !stall;
    assign adv        = in_ready;
    assign busy       = s1.v | s2.v | s3.v | out_valid;
    // Integer bits are always 01 for a legal operand; only the fraction indexes the tables.
    assign unused_msb = ^din[WL-1:WL-2];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1 <= '0;
        end else if (adv) begin
            s1.v   <= in_valid;
            s1.fn  <= func_e'(FUNCTION);
            s1.x   <= din[WL-3:0];
            s1.tag <= in_tag;
        end
    end

    assign addr = s1.x[WL-3 -: LUT_addWidth];

    // Plain registered reads so each table maps onto a block RAM.
    always_ff @(posedge CLK) begin
        if (adv) begin
            rd_rec  <= LUT_rec[addr];
            rd_sqrt <= LUT_sqrt[addr];
            rd_isqt <= LUT_isqt[addr];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s2 <= '0;
        end else if (adv) begin
            s2.v   <= s1.v;
            s2.fn  <= s1.fn;
            s2.xo  <= s1.x[XW-1:0];
            s2.tag <= s1.tag;
        end
    end

    always_comb begin
        sel = '0;
        unique case (1'b1)
            s2.fn == F_REC:  sel = rd_rec;
            s2.fn == F_SQRT: sel = rd_sqrt;
            s2.fn == F_ISQT: sel = rd_isqt;
            default:         sel = '0;
        endcase
    end

    assign c1   = sel[2*LUT_bits-1 -: LUT_bits];
    assign c0   = sel[LUT_bits-1:0];
    assign prod = PW'(c1) * PW'($signed({1'b0, s2.xo}));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s3 <= '0;
        end else if (adv) begin
            s3.v    <= s2.v;
            s3.err  <= (s2.fn == F_ILL);
            s3.prod <= prod;
            s3.c0   <= c0;
            s3.tag  <= s2.tag;
        end
    end

    // Both terms aligned to dWL-2 fraction bits before the add.
    always_comb begin
        acc = ($signed(SW'(s3.c0)) <<< C0SH)
            + (SW'($signed(s3.prod)) >>> SH);
`ifdef HYBRID_ROUND_EN
        acc = acc + (SW'(1) <<< (RB - 1));
`endif
        yq   = acc >>> RB;
        ysat = yq[WL-1:0];
        if (acc[SW-1]) begin
            ysat = '0;
        end else if (|yq[SW-1:WL]) begin
            ysat = '1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (adv) begin
            out_valid <= s3.v;
            if (s3.v) begin
                dout    <= s3.err ? '0 : ysat;
                out_tag <= s3.tag;
                out_err <= s3.err;
            end
        end
    end
endmodule
